// File: rtl/ltc2387_cnv_controller.sv
// LTC2387-18 conversion timing generator: CNV pulses, per-conversion ADC clock-enable
// window, returned-sample counting and a missing-sample watchdog, all on sys_clk.
module ltc2387_cnv_controller #(
    parameter int unsigned CNV_PERIOD = 20,
    parameter int unsigned CNV_HIGH   = 2,
    parameter int unsigned CONV_DELAY = 4,
    parameter int unsigned CLK_PULSES = 9,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] burst_len,
    input  logic        adc_data_valid,
    output logic        cnv,
    output logic        adc_clk_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] samples_captured,
    output logic        timeout_err,
    input  logic        err_clear
);

    localparam int unsigned PW = (CNV_PERIOD > 1) ? $clog2(CNV_PERIOD + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW-1:0] P_LAST      = PW'(CNV_PERIOD - 1);
    localparam logic [PW-1:0] HIGH_END    = PW'(CNV_HIGH);
    localparam logic [PW-1:0] CLKEN_START = PW'(CONV_DELAY);
    localparam logic [PW-1:0] CLKEN_END   = PW'(CONV_DELAY + CLK_PULSES);
    localparam logic [PW-1:0] CLKEN_LAST  = PW'(CONV_DELAY + CLK_PULSES - 1);
    localparam logic [TW-1:0] T_LAST      = TW'(TIMEOUT - 1);

    generate
        if (CNV_HIGH < 1 || CNV_HIGH > CONV_DELAY) begin : g_bad_cnv_high
            $error("CNV_HIGH must lie in 1..CONV_DELAY");
        end
        if (CONV_DELAY + CLK_PULSES > CNV_PERIOD) begin : g_bad_window
            $error("clock window does not fit inside one conversion period");
        end
        if (TIMEOUT < 1 || CLK_PULSES < 1) begin : g_bad_counts
            $error("TIMEOUT and CLK_PULSES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [15:0]   conv_count_q, conv_count_d;
    logic [15:0]   burst_len_q, burst_len_d;
    logic          stop_pending_q, stop_pending_d;

    logic          cnv_q, cnv_d;
    logic          adc_clk_en_q, adc_clk_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   samples_q, samples_d;
    logic          timeout_err_q, timeout_err_d;

    logic          pending_q, pending_d;
    logic [TW-1:0] tcount_q, tcount_d;

    logic          start_accept;
    logic          run_next;
    logic          win_end;
    logic          tmo;
    logic          err_evt;

    // Sequencer: outputs are registered, so they are decoded from the next state and count.
    always_comb begin
        state_d        = state_q;
        p_d            = p_q;
        conv_count_d   = conv_count_q;
        burst_len_d    = burst_len_q;
        stop_pending_d = stop_pending_q;
        start_accept   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stop_pending_d = 1'b0;
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = ST_RUN;
                    p_d          = '0;
                    conv_count_d = '0;
                    burst_len_d  = burst_len;
                end
            end
            ST_RUN: begin
                if (p_q == '0) begin
                    conv_count_d = conv_count_q + 16'd1;
                end
                stop_pending_d = stop_pending_q | stop;
                if (p_q == P_LAST) begin
                    p_d = '0;
                    if (stop_pending_d ||
                        (burst_len_q != '0 && conv_count_d == burst_len_q)) begin
                        state_d = ST_FINISH;
                    end
                end else begin
                    p_d = p_q + PW'(1);
                end
            end
            ST_FINISH: begin
                stop_pending_d = 1'b0;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        run_next     = (state_d == ST_RUN);
        cnv_d        = run_next && (p_d < HIGH_END);
        adc_clk_en_d = run_next && (p_d >= CLKEN_START) && (p_d < CLKEN_END);
        busy_d       = run_next;
        done_d       = (state_d == ST_FINISH);
    end

    // Watchdog arms on the cycle after each window; a fresh window overrides a late sample.
    always_comb begin
        pending_d     = pending_q;
        tcount_d      = tcount_q;
        samples_d     = samples_q;

        win_end = adc_clk_en_q && (p_q == CLKEN_LAST);
        tmo     = pending_q && (tcount_q == T_LAST);
        err_evt = pending_q && !adc_data_valid && (win_end || tmo);

        if (win_end) begin
            pending_d = 1'b1;
            tcount_d  = '0;
        end else if (pending_q) begin
            if (adc_data_valid || tmo) begin
                pending_d = 1'b0;
            end else begin
                tcount_d = tcount_q + TW'(1);
            end
        end

        if (err_evt) begin
            timeout_err_d = 1'b1;
        end else if (err_clear) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end

        if (adc_data_valid && samples_q != '1) begin
            samples_d = samples_q + 16'd1;
        end
        if (start_accept) begin
            samples_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            p_q            <= '0;
            conv_count_q   <= '0;
            burst_len_q    <= '0;
            stop_pending_q <= 1'b0;
            cnv_q          <= 1'b0;
            adc_clk_en_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            samples_q      <= '0;
            timeout_err_q  <= 1'b0;
            pending_q      <= 1'b0;
            tcount_q       <= '0;
        end else begin
            state_q        <= state_d;
            p_q            <= p_d;
            conv_count_q   <= conv_count_d;
            burst_len_q    <= burst_len_d;
            stop_pending_q <= stop_pending_d;
            cnv_q          <= cnv_d;
            adc_clk_en_q   <= adc_clk_en_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            samples_q      <= samples_d;
            timeout_err_q  <= timeout_err_d;
            pending_q      <= pending_d;
            tcount_q       <= tcount_d;
        end
    end

    assign cnv              = cnv_q;
    assign adc_clk_en       = adc_clk_en_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign samples_captured = samples_q;
    assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_ltc2387_cnv_controller.sv
// Bench for ltc2387_cnv_controller: directed timing scenarios plus randomized acquisitions,
// checked every cycle against a cycle-arithmetic reference model.
module tb_ltc2387_cnv_controller;

    localparam int P  = 20;
    localparam int CH = 2;
    localparam int CD = 4;
    localparam int CP = 9;
    localparam int TO = 32;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] burst_len = '0;
    logic        adc_data_valid = 1'b0;
    logic        cnv;
    logic        adc_clk_en;
    logic        busy;
    logic        done;
    logic [15:0] samples_captured;
    logic        timeout_err;
    logic        err_clear = 1'b0;

    ltc2387_cnv_controller #(
        .CNV_PERIOD (P),
        .CNV_HIGH   (CH),
        .CONV_DELAY (CD),
        .CLK_PULSES (CP),
        .TIMEOUT    (TO)
    ) dut (
        .sys_clk          (sys_clk),
        .reset            (reset),
        .start            (start),
        .stop             (stop),
        .burst_len        (burst_len),
        .adc_data_valid   (adc_data_valid),
        .cnv              (cnv),
        .adc_clk_en       (adc_clk_en),
        .busy             (busy),
        .done             (done),
        .samples_captured (samples_captured),
        .timeout_err      (timeout_err),
        .err_clear        (err_clear)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state
    bit m_run, m_fin, m_stop, m_err, w_pend;
    int m_t0, m_bl, m_samples, w_arm;
    int vdelay = 5;
    bit vsched [int];

    // per-scenario observations of the DUT
    int s0, rises, first_cnv, en_cnt, en_last, done_cnt, done_cyc;
    bit prev_cnv;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model across the edge that opens cycle e, using the inputs held before it.
    task automatic model_step(input int e);
        int  pp, prev_p, prev_k;
        bit  win_end, tmo, err_evt, v;
        v = adc_data_valid;
        if (reset) begin
            m_run = 0; m_fin = 0; m_stop = 0; m_err = 0; w_pend = 0;
            m_samples = 0; m_bl = 0;
            vsched.delete();
            return;
        end
        pp      = e - 1 - m_t0;
        prev_p  = pp % P;
        prev_k  = pp / P + 1;
        win_end = m_run && (prev_p == CD + CP - 1);
        tmo     = w_pend && ((e - 1 - w_arm) == TO - 1);
        err_evt = w_pend && !v && (win_end || tmo);
        if (win_end) begin
            w_pend = 1; w_arm = e;
            if (vdelay >= 0) vsched[e + vdelay] = 1'b1;
        end else if (w_pend && (v || tmo)) begin
            w_pend = 0;
        end
        if (err_evt) m_err = 1;
        else if (err_clear) m_err = 0;
        if (v && m_samples < 65535) m_samples++;
        if (m_fin) begin
            m_fin = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_t0 = e; m_bl = int'(burst_len); m_stop = 0; m_samples = 0;
            end
        end else begin
            if (stop) m_stop = 1;
            if (prev_p == P - 1 && (m_stop || (m_bl != 0 && prev_k == m_bl))) begin
                m_run = 0; m_fin = 1;
            end
        end
    endtask

    task automatic tick();
        int  p;
        bit  e_cnv, e_en;
        adc_data_valid = vsched.exists(cyc);
        @(posedge sys_clk);
        cyc++;
        model_step(cyc);
        p     = (cyc - m_t0) % P;
        e_cnv = m_run && (p < CH);
        e_en  = m_run && (p >= CD) && (p < CD + CP);
        #1;
        check_eq("cnv", 16'(cnv), 16'(e_cnv));
        check_eq("adc_clk_en", 16'(adc_clk_en), 16'(e_en));
        check_eq("busy", 16'(busy), 16'(m_run));
        check_eq("done", 16'(done), 16'(m_fin));
        check_eq("samples", samples_captured, 16'(m_samples));
        check_eq("timeout_err", 16'(timeout_err), 16'(m_err));
        if (cnv === 1'b1 && !prev_cnv) begin
            rises++;
            if (first_cnv < 0) first_cnv = cyc;
        end
        prev_cnv = (cnv === 1'b1);
        if (adc_clk_en === 1'b1) begin en_cnt++; en_last = cyc; end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        start = 0; stop = 0; err_clear = 0; reset = 0;
    endtask

    task automatic begin_scn(input int bl, input int vd);
        burst_len = 16'(bl);
        vdelay    = vd;
        start     = 1;
        s0        = cyc;
        rises = 0; first_cnv = -1; en_cnt = 0; en_last = -1; done_cnt = 0; done_cyc = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic single_shot(input string pfx);
        begin_scn(1, 5);
        while (cyc - s0 < 40) tick();
        check_eq({pfx, "_cnv_first"}, 16'(first_cnv - s0), 16'd1);
        check_eq({pfx, "_cnv_rises"}, 16'(rises), 16'd1);
        check_eq({pfx, "_en_count"}, 16'(en_cnt), 16'd9);
        check_eq({pfx, "_en_last"}, 16'(en_last - s0), 16'd13);
        check_eq({pfx, "_done_at"}, 16'(done_cyc - s0), 16'd21);
        check_eq({pfx, "_samples"}, samples_captured, 16'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit cycle %0d: simulation did not finish", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int bl, stop_at, rst_at, budget;
        prev_cnv = 0;
        reset = 1;
        tick();
        reset = 1;
        tick();
        idle(2);

        single_shot("ss");
        idle(40);

        // burst of 3, sample returned 5 cycles after each window
        begin_scn(3, 5);
        while (cyc - s0 < 80) tick();
        check_eq("b3_rises", 16'(rises), 16'd3);
        check_eq("b3_done_at", 16'(done_cyc - s0), 16'd61);
        check_eq("b3_samples", samples_captured, 16'd3);
        check_eq("b3_err", 16'(timeout_err), 16'd0);
        idle(40);

        // continuous, stopped during the second period
        begin_scn(0, 5);
        while (cyc - s0 < 70) begin
            if (cyc - s0 == 30) stop = 1;
            tick();
        end
        check_eq("cont_rises", 16'(rises), 16'd2);
        check_eq("cont_done_at", 16'(done_cyc - s0), 16'd41);
        check_eq("cont_en_last", 16'(en_last - s0), 16'd33);
        idle(40);

        // missing samples, then error clear
        begin_scn(2, -1);
        while (cyc - s0 < 36) tick();
        check_eq("miss_err_set", 16'(timeout_err), 16'd1);
        while (cyc - s0 < 90) tick();
        err_clear = 1;
        tick();
        check_eq("miss_err_cleared", 16'(timeout_err), 16'd0);
        idle(20);
        check_eq("miss_err_stays", 16'(timeout_err), 16'd0);
        idle(10);

        // reset during a burst
        begin_scn(3, 5);
        while (cyc - s0 < 8) tick();
        reset = 1;
        tick();
        check_eq("rst_cnv", 16'(cnv), 16'd0);
        check_eq("rst_en", 16'(adc_clk_en), 16'd0);
        check_eq("rst_busy", 16'(busy), 16'd0);
        idle(30);
        check_eq("rst_no_done", 16'(done_cnt), 16'd0);
        single_shot("rs");
        idle(40);

        // start re-pulsed while busy and in the FINISH cycle
        begin_scn(2, 3);
        while (cyc - s0 < 70) begin
            if (cyc - s0 == 10 || cyc - s0 == 41) begin
                start = 1;
                burst_len = 16'd5;
            end
            tick();
        end
        check_eq("rep_rises", 16'(rises), 16'd2);
        check_eq("rep_done_at", 16'(done_cyc - s0), 16'd41);
        check_eq("rep_samples", samples_captured, 16'd2);
        idle(40);

        // randomized acquisitions
        for (int it = 0; it < 30; it++) begin
            bl      = $urandom_range(0, 4);
            stop_at = (bl == 0 || $urandom_range(0, 3) == 0) ? int'($urandom_range(2, 70)) : -1;
            rst_at  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 60)) : -1;
            begin_scn(bl, ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 40)));
            tick();
            budget = 0;
            while ((m_run || m_fin) && budget < 200) begin
                burst_len = 16'($urandom_range(0, 5));
                if (cyc - s0 == stop_at) stop = 1;
                if (cyc - s0 == rst_at) reset = 1;
                if ($urandom_range(0, 15) == 0) start = 1;
                if ($urandom_range(0, 24) == 0) err_clear = 1;
                tick();
                budget++;
            end
            if (budget >= 200) check_eq("rnd_sequence_end", 16'd0, 16'd1);
            for (int i = 0; i < int'($urandom_range(0, 40)); i++) begin
                if ($urandom_range(0, 24) == 0) err_clear = 1;
                if ($urandom_range(0, 30) == 0) stop = 1;
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
